// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Boot-time writer for the instruction memory. It accepts a header word
//   (word count N) and then N instruction words over a valid/ready stream.
//   It writes those words to addresses 0..N-1 and holds the core in reset
//   until loading has finished.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   reset        synchronous, active-high reset
//   in_valid     stream word valid
//   in_data      stream word (header or instruction)
//   in_ready     loader accepts in_data this cycle (decoded from state only)
//   mem_we       instruction memory write enable (registered)
//   mem_addr     instruction memory word address (registered)
//   mem_wdata    instruction memory write data (registered)
//   cpu_reset    active-high reset to the processor core
//   done         load finished successfully
//   error        header rejected (N larger than memory depth)
//   words_loaded number of words written so far
module imem_stream_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CW = ADDR_WIDTH + 1;
  // Largest legal word count (the full memory depth), held at full header
  // width so that oversize headers are never truncated before the compare.
  localparam logic [DATA_WIDTH-1:0] MAX_N = DATA_WIDTH'(1) << ADDR_WIDTH;

  // S_FLUSH is the cycle in which the final write is on the memory port.
  // A zero-length header passes through it as well, so that done always
  // rises two edges after the last accepted word.
  typedef enum logic [2:0] {
    S_HEADER,
    S_LOAD,
    S_FLUSH,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         n_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  error_q;
  logic                  xfer;
  logic                  last_word;

  assign in_ready  = (state_q == S_HEADER) || (state_q == S_LOAD);
  assign xfer      = in_valid && in_ready;
  // The counter is one bit wider than the address. This lets N equal to
  // the full depth finish without the pointer wrapping back to zero.
  assign cnt_d     = cnt_q + CW'(1);
  assign last_word = (cnt_d == n_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HEADER;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_HEADER: begin
          if (xfer) begin
            cnt_q <= '0;
            if (in_data == '0) begin
              state_q <= S_FLUSH;
            end else if (in_data > MAX_N) begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end else begin
              n_q     <= in_data[CW-1:0];
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= cnt_q[ADDR_WIDTH-1:0];
            mem_wdata_q <= in_data;
            cnt_q       <= cnt_d;
            if (last_word) begin
              state_q <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          state_q     <= S_DONE;
          cpu_reset_q <= 1'b0;
          done_q      <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        S_ERROR: begin
          state_q <= S_ERROR;
        end
        default: begin
          state_q <= S_ERROR;
          error_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = cnt_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          e;
  } wr_t;
  wr_t exp_q[$];

  imem_stream_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every write on the memory port must match the next expected one,
  // including the edge on which it appears.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", {56'd0, mem_addr}, 64'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", {56'd0, mem_addr}, {56'd0, w.a});
        chk("wr_data", {32'd0, mem_wdata}, {32'd0, w.d});
        chk("wr_cycle", 64'(cyc), 64'(w.e));
      end
    end
  end

  // Offers one word; the transfer happens on the following rising edge.
  task automatic send(input logic [31:0] d, input bit is_wr, input logic [7:0] a);
    logic rdy;
    int   e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    rdy      = in_ready;
    e        = cyc + 1;
    if (is_wr && rdy) begin
      wr_t w;
      w.a = a; w.d = d; w.e = e;
      exp_q.push_back(w);
    end
    @(posedge clk);
    chk("ready_on_send", {63'd0, rdy}, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mem_we",    {63'd0, mem_we},    64'd0);
    chk("rst_mem_addr",  {56'd0, mem_addr},  64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("rst_done",      {63'd0, done},      64'd0);
    chk("rst_error",     {63'd0, error},     64'd0);
    chk("rst_words",     {55'd0, words_loaded}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
  endtask

  // Called right after the last transfer edge t: done must rise at t+2.
  task automatic check_done(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_done_t0"},  {63'd0, done},      64'd0);
    chk({tag, "_ready_t0"}, {63'd0, in_ready},  64'd0);
    @(negedge clk);
    chk({tag, "_done_t1"},  {63'd0, done},      64'd0);
    chk({tag, "_cpurst_t1"}, {63'd0, cpu_reset}, 64'd1);
    @(negedge clk);
    chk({tag, "_done_t2"},  {63'd0, done},      64'd1);
    chk({tag, "_cpurst_t2"}, {63'd0, cpu_reset}, 64'd0);
    chk({tag, "_ready_t2"}, {63'd0, in_ready},  64'd0);
  endtask

  task automatic check_error(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_error"},  {63'd0, error},     64'd1);
    chk({tag, "_cpurst"}, {63'd0, cpu_reset}, 64'd1);
    chk({tag, "_ready"},  {63'd0, in_ready},  64'd0);
    chk({tag, "_done"},   {63'd0, done},      64'd0);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_error_hold"}, {63'd0, error},    64'd1);
    chk({tag, "_words"},      {55'd0, words_loaded}, 64'd0);
  endtask

  logic [31:0] prog [3] = '{32'h20080005, 32'h20090007, 32'h01095020};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    do_reset();

    // Basic back-to-back load
    send(32'd3, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) send(prog[i], 1'b1, 8'(i));
    check_done("basic");
    chk("basic_words", {55'd0, words_loaded}, 64'd3);

    // Post-done isolation
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      if (i == 9) chk("iso_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("iso_done", {63'd0, done}, 64'd1);

    // Stalled source
    do_reset();
    send(32'd3, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      idle(4);
      send(prog[i], 1'b1, 8'(i));
    end
    check_done("stall");
    chk("stall_words", {55'd0, words_loaded}, 64'd3);

    // Zero-length header
    do_reset();
    send(32'd0, 1'b0, 8'd0);
    check_done("zero");
    chk("zero_words", {55'd0, words_loaded}, 64'd0);

    // Oversize headers
    do_reset();
    send(32'd257, 1'b0, 8'd0);
    check_error("hdr257");
    do_reset();
    send(32'h80000001, 1'b0, 8'd0);
    check_error("hdr8000");

    // Full depth
    do_reset();
    send(32'd256, 1'b0, 8'd0);
    for (int i = 0; i < 256; i++) send(32'(i) ^ 32'hA5A5A5A5, 1'b1, 8'(i));
    check_done("full");
    chk("full_words", {55'd0, words_loaded}, 64'd256);

    // Reset in the middle of a load, then a fresh one-word load
    do_reset();
    send(32'd5, 1'b0, 8'd0);
    send(32'h11111111, 1'b1, 8'd0);
    send(32'h22222222, 1'b1, 8'd1);
    do_reset();
    send(32'd1, 1'b0, 8'd0);
    send(32'hCAFEF00D, 1'b1, 8'd0);
    check_done("after_abort");
    chk("after_abort_words", {55'd0, words_loaded}, 64'd1);

    idle(3);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Boot-time writer for the single-cycle processor's instruction memory.
- Accepts a word stream over a valid/ready handshake: one header word (word count N), then N instruction words.
- Writes the N words to instruction memory addresses 0..N-1 and holds the processor core in reset until loading is complete.
- Sits between the off-chip/bench stream source and the instruction memory write port; its cpu_reset output drives the core's reset.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction word width; the header word has the same width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  stream word valid.
- in_data  input  DATA_WIDTH  stream word (header or instruction).
- in_ready  output  1  loader can accept in_data this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_addr  output  ADDR_WIDTH  write word address.
- mem_wdata  output  DATA_WIDTH  write data.
- cpu_reset  output  1  reset to processor core, active-high.
- done  output  1  load finished successfully.
- error  output  1  header rejected.
- words_loaded  output  ADDR_WIDTH+1  count of words written so far.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=HEADER, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0.
- Reset asserted mid-load aborts immediately and returns to these values. Words already written stay in memory; no clearing.
- Handshake: a word transfers on a rising edge with in_valid=1 and in_ready=1.
  - in_ready is combinational from state only: 1 in HEADER and LOAD, 0 otherwise.
  - in_data is ignored when no transfer occurs. The source may hold in_valid low for any number of cycles.
- HEADER state, on transfer:
  - Latch N = in_data.
  - N=0: go to DRAIN (no writes).
  - N > 2^ADDR_WIDTH (full DATA_WIDTH compare, no truncation): go to ERROR.
  - Otherwise: go to LOAD with write pointer=0.
- LOAD state, on transfer at edge t:
  - From t, for exactly one cycle: mem_we=1, mem_addr=pointer, mem_wdata=in_data. Registered outputs, so the write is presented one cycle after acceptance.
  - Pointer and words_loaded increment.
  - If this was word N, go to DRAIN; else stay in LOAD.
  - Back-to-back transfers give back-to-back writes.
  - mem_we=0 in every cycle not immediately following a LOAD transfer.
- DRAIN: lasts exactly one cycle so the final write completes, then go to DONE.
- DONE: cpu_reset=0, done=1, in_ready=0. Held until reset.
- ERROR: cpu_reset=1, error=1, done=0, in_ready=0, mem_we=0. Held until reset.
- cpu_reset, done and error are registered from state; they change on the edge that enters DONE/ERROR.
- Timing from the last LOAD transfer at edge t:
  - final write occupies cycle [t, t+1);
  - DRAIN in cycle [t+1, t+2);
  - cpu_reset falls and done rises at edge t+2.
- Address wrap: with N = 2^ADDR_WIDTH, the last write is to address 2^ADDR_WIDTH-1. The pointer must not wrap before the transition to DRAIN. words_loaded reaches 2^ADDR_WIDTH (hence the extra bit).
- The header word itself is never written to memory.

Test Plan:
- Basic load, ADDR_WIDTH=8: stream header 3, then 0x20080005, 0x20090007, 0x01095020, all back-to-back → mem_we high 3 consecutive cycles at addr 0,1,2 with matching data; done=1 and cpu_reset=0 exactly 2 cycles after the last transfer; words_loaded=3.
- Stalled source: same stream with in_valid low for 4 cycles between every word → same three writes, each one cycle after its transfer; mem_we=0 during gaps; final timing relative to the last transfer unchanged.
- Zero and oversize header:
  - header 0 → no mem_we ever; DRAIN then DONE (done=1 two cycles after the header transfer).
  - Separately, header 257 (and 0x80000001) → error=1, cpu_reset stays 1, in_ready=0, no writes.
- Full depth: header 256, then 256 words of value = address XOR 0xA5A5A5A5 → last write at addr 0xFF, words_loaded=256, done=1, no write to addr 0.
- Reset mid-operation: assert reset for 1 cycle after 2 of 5 words → all outputs return to reset values next edge, cpu_reset=1. A fresh header 1 plus one word then loads addr 0 and reaches done.
- Post-done isolation: after done, hold in_valid=1 with arbitrary data for 10 cycles → in_ready=0, mem_we=0, done stays 1.
